// File: rtl/booth_r8_pkg.sv
// booth_r8_pkg: shared types and sizing helpers for the radix-8 Booth multiplier.
package booth_r8_pkg;
   typedef enum logic [1:0] {IDLE, PRE, ITER, DONE} state_t;
   typedef enum logic [3:0] {ZERO, P1, P2, P3, P4, M1, M2, M3, M4} dsel_t;
   // Radix-8 digit count, wide enough to include the unsigned zero-extension bit.
   function automatic int num_pp(input int n);
      return (n + 3) / 3;
   endfunction
endpackage

// File: rtl/booth_r8_seq_mult_if.sv
// booth_r8_seq_mult_if: operand/result handshake bundle for the Booth multiplier.
interface booth_r8_seq_mult_if #(
   parameter int N = 16
);
   logic in_valid, in_ready, is_signed, out_valid, out_ready, busy;
   logic [N-1:0] a, b;
   logic [2*N-1:0] prod;
   modport master (output in_valid, a, b, is_signed, out_ready, input in_ready, out_valid, prod, busy);
   modport slave (input in_valid, a, b, is_signed, out_ready, output in_ready, out_valid, prod, busy);
endinterface

// File: rtl/booth_r8_digit_sel.sv
// booth_r8_digit_sel: recodes one 4-bit overlapping radix-8 digit into a signed multiple of A.
module booth_r8_digit_sel
   import booth_r8_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [3:0]   digit,
   input  logic [N+2:0] a,
   input  logic [N+2:0] a3,
   output logic [N+3:0] m
);
   dsel_t sel;
   logic [N+3:0] ax, a3x, mag;
   always_comb begin
      case (digit)
         4'b0001, 4'b0010: sel = P1;
         4'b0011, 4'b0100: sel = P2;
         4'b0101, 4'b0110: sel = P3;
         4'b0111:          sel = P4;
         4'b1000:          sel = M4;
         4'b1001, 4'b1010: sel = M3;
         4'b1011, 4'b1100: sel = M2;
         4'b1101, 4'b1110: sel = M1;
         default:          sel = ZERO;
      endcase
   end
   assign ax  = {a[N+2], a};
   assign a3x = {a3[N+2], a3};
   assign mag = (sel == P1 || sel == M1) ? ax :
                (sel == P2 || sel == M2) ? ax << 1 :
                (sel == P3 || sel == M3) ? a3x :
                (sel == P4 || sel == M4) ? ax << 2 : '0;
   assign m = (sel == M1 || sel == M2 || sel == M3 || sel == M4) ? -mag : mag;
endmodule

// File: rtl/booth_r8_seq_mult.sv
// booth_r8_seq_mult: sequential radix-8 Booth multiplier retiring one digit per cycle,
// with per-operation signed/unsigned selection and valid/ready handshakes.
module booth_r8_seq_mult
   import booth_r8_pkg::*;
#(
   parameter int N = 16
) (
   input logic clk,
   input logic rst,
   booth_r8_seq_mult_if.slave bus
);
   localparam int P  = num_pp(N);
   localparam int T  = 3 * P;
   localparam int W  = N + 4 + T;
   localparam int CW = $clog2(P + 1);
   state_t state;
   logic [N-1:0] a_r, b_r;
   logic sgn_r;
   logic [N+2:0] a_x, a_e, a3_r;
   logic [N+3:0] q_r, m;
   logic [W-1:0] acc, acc_nxt;
   logic signed [W-1:0] sum;
   logic [CW-1:0] cnt;
   logic [2*N-1:0] prod_r;
   assign a_x = {{3{sgn_r & a_r[N-1]}}, a_r};
   booth_r8_digit_sel #(.N(N)) u_sel (.digit(q_r[3:0]), .a(a_e), .a3(a3_r), .m(m));
   // Multiple lands on the top field; the shift brings the next digit's weight into place.
   assign sum     = acc + {m, {T{1'b0}}};
   assign acc_nxt = sum >>> 3;
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.prod      = prod_r;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_r    <= '0;
         b_r    <= '0;
         sgn_r  <= 1'b0;
         a_e    <= '0;
         a3_r   <= '0;
         q_r    <= '0;
         acc    <= '0;
         cnt    <= '0;
         prod_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_r   <= bus.a;
               b_r   <= bus.b;
               sgn_r <= bus.is_signed;
               state <= PRE;
            end
            PRE: begin
               a_e   <= a_x;
               a3_r  <= a_x + {a_x[N+1:0], 1'b0};
               q_r   <= {{3{sgn_r & b_r[N-1]}}, b_r, 1'b0};
               acc   <= '0;
               cnt   <= '0;
               state <= ITER;
            end
            ITER: if (cnt == CW'(P)) begin
               prod_r <= acc[2*N-1:0];
               state  <= DONE;
            end else begin
               acc <= acc_nxt;
               q_r <= {{3{q_r[N+3]}}, q_r[N+3:3]};
               cnt <= cnt + 1'b1;
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// tb_booth_r8_seq_mult: directed N=16 checks plus concurrent randomised N=8/16/24 scoreboards.
module tb_booth_r8_seq_mult;
   localparam int NOPS = 3334;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_r = 1'b1;
   int checks = 0;
   int failures = 0;
   logic [127:0] sbq[$];
   typedef struct {logic [15:0] a; logic [15:0] b; logic s; logic [31:0] p;} vec_t;
   vec_t vecs[4];
   always #5 clk = ~clk;
   booth_r8_seq_mult_if #(.N(16)) bus ();
   booth_r8_seq_mult #(.N(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [127:0] ref_mul(input int n, input logic [63:0] a, input logic [63:0] b, input logic s);
      logic signed [127:0] x, y, p;
      for (int i = 0; i < 128; i++) begin
         x[i] = (i < n) ? a[i] : (s & a[n-1]);
         y[i] = (i < n) ? b[i] : (s & b[n-1]);
      end
      p = x * y;
      for (int i = 2 * n; i < 128; i++) p[i] = 1'b0;
      return p;
   endfunction
   function automatic logic [63:0] pick(input int n);
      case ($urandom_range(0, 7))
         0: return '0;
         1: return ~64'(0) >> (64 - n);
         2: return 64'(1) << (n - 1);
         3: return 64'(1);
         default: return {$urandom, $urandom};
      endcase
   endfunction
   always @(negedge clk) if (rst) begin
      if (bus.in_valid && bus.in_ready) sbq.push_back(ref_mul(16, 64'(bus.a), 64'(bus.b), bus.is_signed));
      if (bus.out_valid && bus.out_ready) begin
         if (sbq.size() == 0) chk("sb_empty", 1, 0);
         else chk("sb_prod", 128'(bus.prod), sbq.pop_front());
      end
   end
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(posedge clk);
      #1 bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      bus.is_signed = s;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      bus.is_signed = ~s;
   endtask
   task automatic wait_valid();
      int i = 0;
      while (!bus.out_valid && i < 40) begin
         @(posedge clk);
         #1 i++;
      end
      if (!bus.out_valid) chk("timeout", 0, 1);
   endtask
   for (genvar g = 0; g < 3; g++) begin : g_rand
      localparam int NW = 8 + 8 * g;
      booth_r8_seq_mult_if #(.N(NW)) rb ();
      booth_r8_seq_mult #(.N(NW)) rdut (.clk(clk), .rst(rst_r), .bus(rb));
      logic [127:0] q[$];
      int acc_n = 0;
      bit done = 1'b0;
      always @(negedge clk) if (rst_r) begin
         if (rb.in_valid && rb.in_ready) begin
            q.push_back(ref_mul(NW, 64'(rb.a), 64'(rb.b), rb.is_signed));
            acc_n++;
         end
         if (rb.out_valid && rb.out_ready) begin
            if (q.size() == 0) chk("rand_empty", 1, 0);
            else chk($sformatf("rand_n%0d", NW), 128'(rb.prod), q.pop_front());
         end
      end
      initial begin
         rb.in_valid = 1'b0;
         rb.a = '0;
         rb.b = '0;
         rb.is_signed = 1'b0;
         rb.out_ready = 1'b0;
         #3 wait (rst_r);
         while (acc_n < NOPS) begin
            @(posedge clk);
            #1 rb.in_valid = $urandom_range(0, 3) != 0;
            rb.a = NW'(pick(NW));
            rb.b = NW'(pick(NW));
            rb.is_signed = 1'($urandom_range(0, 1));
            rb.out_ready = $urandom_range(0, 3) != 0;
         end
         rb.in_valid = 1'b0;
         rb.out_ready = 1'b1;
         for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
         chk($sformatf("rand_drain_n%0d", NW), q.size(), 0);
         done = 1'b1;
      end
   end
   initial begin
      vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
      vecs[1] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};
      vecs[3] = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.is_signed = 1'b0;
      bus.out_ready = 1'b0;
      #2 rst = 1'b0;
      rst_r = 1'b0;
      #10;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_prod", bus.prod, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      rst_r = 1'b1;
      start_op(16'h8000, 16'h8000, 1'b1);
      repeat (7) @(posedge clk);
      #1 chk("lat_edge7", bus.out_valid, 0);
      @(posedge clk);
      #1 chk("lat_edge8", bus.out_valid, 1);
      chk("sgn_min", bus.prod, 32'h40000000);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a = 16'($urandom);
         bus.b = 16'($urandom);
         @(posedge clk);
         #1 chk("bp_valid", bus.out_valid, 1);
         chk("bp_prod", bus.prod, 32'h40000000);
         chk("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 chk("bp_idle", bus.in_ready, 1);
      chk("bp_out_valid", bus.out_valid, 0);
      chk("hold_prod", bus.prod, 32'h40000000);
      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_valid();
         @(posedge clk);
         #1 chk($sformatf("vec%0d", i), bus.prod, vecs[i].p);
      end
      bus.out_ready = 1'b0;
      start_op(16'h1234, 16'h0567, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      sbq.delete();
      #1 chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_prod", bus.prod, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.a = 16'd7;
      bus.b = 16'd9;
      bus.is_signed = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1 chk("first_accept", bus.busy, 1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_valid();
      chk("rst_7x9", bus.prod, 32'd63);
      @(posedge clk);
      #1 chk("sb_left", sbq.size(), 0);
      for (int i = 0; i < 80000 && !(g_rand[0].done && g_rand[1].done && g_rand[2].done); i++) @(posedge clk);
      if (!(g_rand[0].done && g_rand[1].done && g_rand[2].done)) chk("rand_timeout", 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
